// File: rtl/bus_interconnect.sv
// bus_interconnect: routes the picorv32 native memory port to NUM_SLAVES
// peripheral slaves selected by an address field. Responses are registered,
// unmapped or hung accesses end in an error response, and a small set of
// error status registers is kept for debug.
//
// Handshake: the core raises m_valid and holds m_addr/m_wdata/m_wstrb stable
// until it sees the one-cycle m_ready pulse; a slave sees s_valid[i] held high
// while it owns the transfer and completes it by raising s_ready[i] for one
// cycle; s_ready is only honoured from the selected slave while ACTIVE.
//
// dbg_state encoding: 0 = IDLE, 1 = ACTIVE, 2 = RESP.

module bus_interconnect #(
   parameter int          NUM_SLAVES = 4,
   parameter int          SEL_MSB    = 31,
   parameter int          SEL_LSB    = 28,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
   input  logic                       clk,
   input  logic                       resetn,
   // core side
   input  logic                       m_valid,
   input  logic [31:0]                m_addr,
   input  logic [31:0]                m_wdata,
   input  logic [3:0]                 m_wstrb,
   output logic                       m_ready,
   output logic [31:0]                m_rdata,
   // slave side
   output logic [NUM_SLAVES-1:0]      s_valid,
   output logic [31:0]                s_addr,
   output logic [31:0]                s_wdata,
   output logic [3:0]                 s_wstrb,
   input  logic [NUM_SLAVES-1:0]      s_ready,
   input  logic [32*NUM_SLAVES-1:0]   s_rdata,
   // error status
   output logic                       bus_error,
   output logic [31:0]                err_addr,
   output logic [15:0]                err_count,
   // debug
   output logic [1:0]                 dbg_state
);

   localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
   localparam int SW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           sel_q;
   logic [TW-1:0]           timer_q;
   logic                    err_flag_q;
   logic [NUM_SLAVES-1:0]   s_valid_q;
   logic [31:0]             m_rdata_q;
   logic [31:0]             err_addr_q;
   logic [15:0]             err_count_q;

   logic [SEL_W-1:0]        field;
   logic [31:0]             field_ext;
   logic                    mapped;
   logic [NUM_SLAVES-1:0]   dec_onehot;
   logic                    sel_ready;
   logic [31:0]             sel_rdata;

   // FSM decisions
   logic                    start;
   logic                    unmapped_hit;
   logic                    slave_done;
   logic                    timed_out;
   logic                    timer_hit;

   // Address pass-through: the core holds these stable for the whole transfer.
   assign s_addr  = m_addr;
   assign s_wdata = m_wdata;
   assign s_wstrb = m_wstrb;

   assign field     = m_addr[SEL_MSB:SEL_LSB];
   assign field_ext = 32'(field);
   assign mapped    = (field_ext < 32'(NUM_SLAVES));

   // One-hot decode of the select field, zero when the field is unmapped.
   always_comb begin
      dec_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (field_ext == 32'(i)) begin
            dec_onehot[i] = 1'b1;
         end
      end
   end

   // Pick the ready and read data of the latched slave; others are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SW'(i)) begin
            sel_ready = s_ready[i];
            sel_rdata = s_rdata[32*i +: 32];
         end
      end
   end

   // The timeout fires on the last allowed ACTIVE cycle; TIMEOUT=0 disables it.
   assign timer_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-cycle decisions for the datapath.
   always_comb begin
      state_d      = state_q;
      start        = 1'b0;
      unmapped_hit = 1'b0;
      slave_done   = 1'b0;
      timed_out    = 1'b0;
      case (state_q)
         IDLE: begin
            if (m_valid) begin
               if (mapped) begin
                  start   = 1'b1;
                  state_d = ACTIVE;
               end else begin
                  unmapped_hit = 1'b1;
                  state_d      = RESP;
               end
            end
         end
         ACTIVE: begin
            // A ready on the final allowed cycle still wins over the timeout.
            if (sel_ready) begin
               slave_done = 1'b1;
               state_d    = RESP;
            end else if (timer_hit) begin
               timed_out = 1'b1;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slave select, wait timer and registered one-hot slave request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_q     <= '0;
         timer_q   <= '0;
         s_valid_q <= '0;
      end else begin
         if (start) begin
            sel_q     <= SW'(field);
            timer_q   <= '0;
            s_valid_q <= dec_onehot;
         end else if (slave_done || timed_out) begin
            s_valid_q <= '0;
         end else if (state_q == ACTIVE) begin
            timer_q <= timer_q + TW'(1);
         end
      end
   end

   // Response data, error flag and error status registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_rdata_q   <= '0;
         err_flag_q  <= 1'b0;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         if (slave_done) begin
            m_rdata_q  <= sel_rdata;
            err_flag_q <= 1'b0;
         end else if (timed_out || unmapped_hit) begin
            m_rdata_q  <= ERR_RDATA;
            err_addr_q <= m_addr;
            err_flag_q <= 1'b1;
         end
         // Count once per errored response, holding at all-ones.
         if ((state_q == RESP) && err_flag_q && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end
   end

   assign m_ready   = (state_q == RESP);
   assign bus_error = (state_q == RESP) && err_flag_q;
   assign m_rdata   = m_rdata_q;
   assign s_valid   = s_valid_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed transactions against bus_interconnect with a
// transaction-level model that predicts every cycle's outputs from the
// addressing, latency and timeout rules, plus literal spot checks.

module tb_bus_interconnect;

   localparam int          NS  = 4;
   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   // clock / reset
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   // DUT signals
   logic              m_valid;
   logic [31:0]       m_addr;
   logic [31:0]       m_wdata;
   logic [3:0]        m_wstrb;
   logic              m_ready;
   logic [31:0]       m_rdata;
   logic [NS-1:0]     s_valid;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic [NS-1:0]     s_ready;
   logic [32*NS-1:0]  s_rdata;
   logic              bus_error;
   logic [31:0]       err_addr;
   logic [15:0]       err_count;
   logic [1:0]        dbg_state;

   bus_interconnect #(
      .NUM_SLAVES (NS),
      .SEL_MSB    (31),
      .SEL_LSB    (28),
      .TIMEOUT    (TMO),
      .ERR_RDATA  (ERR)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .m_valid   (m_valid),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_ready   (m_ready),
      .m_rdata   (m_rdata),
      .s_valid   (s_valid),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_ready   (s_ready),
      .s_rdata   (s_rdata),
      .bus_error (bus_error),
      .err_addr  (err_addr),
      .err_count (err_count),
      .dbg_state (dbg_state)
   );

   // model state: what each output must show in the current cycle
   logic [NS-1:0] exp_s_valid;
   logic          exp_m_ready;
   logic          exp_bus_error;
   logic [31:0]   exp_m_rdata;
   logic [31:0]   exp_err_addr;
   logic [15:0]   exp_err_count;
   logic [1:0]    exp_state;
   logic          bump;
   logic [32:0]   exp_q[$];
   logic [32:0]   resp_exp;

   int checks = 0;
   int errors = 0;

   // observation counters for literal checks
   int sv_cnt[NS];
   int rdy_cnt = 0;
   int sv_base[NS];
   int rdy_base;
   logic [31:0] last_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: every cycle after negedge
   always @(negedge clk) begin
      chk("s_valid", 32'(s_valid), 32'(exp_s_valid));
      chk("m_ready", 32'(m_ready), 32'(exp_m_ready));
      chk("bus_error", 32'(bus_error), 32'(exp_bus_error));
      chk("m_rdata", m_rdata, exp_m_rdata);
      chk("err_addr", err_addr, exp_err_addr);
      chk("err_count", 32'(err_count), 32'(exp_err_count));
      chk("dbg_state", 32'(dbg_state), 32'(exp_state));
      chk("s_addr", s_addr, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
      chk("s_wstrb", 32'(s_wstrb), 32'(m_wstrb));
      if (m_ready) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'(m_ready), 32'd0);
         end else begin
            resp_exp = exp_q.pop_front();
            chk("resp_err", 32'(bus_error), 32'(resp_exp[32]));
            chk("resp_rdata", m_rdata, resp_exp[31:0]);
         end
      end
   end

   // monitor: per-slave request cycles and response pulses
   always @(negedge clk) begin
      for (int i = 0; i < NS; i++) begin
         sv_cnt[i] = sv_cnt[i] + int'(s_valid[i]);
      end
      rdy_cnt = rdy_cnt + int'(m_ready);
   end

   task automatic snap();
      for (int i = 0; i < NS; i++) sv_base[i] = sv_cnt[i];
      rdy_base = rdy_cnt;
   endtask

   function automatic int sv_delta(input int i);
      return sv_cnt[i] - sv_base[i];
   endfunction

   // advance one cycle; noise on slave inputs that the DUT must ignore
   task automatic step();
      @(posedge clk);
      #1;
      if (bump) begin
         if (exp_err_count != 16'hFFFF) exp_err_count = exp_err_count + 16'd1;
         bump = 1'b0;
      end
      exp_s_valid   = '0;
      exp_m_ready   = 1'b0;
      exp_bus_error = 1'b0;
      exp_state     = 2'd0;
      s_ready       = 4'($urandom_range(0, 15));
      s_rdata       = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic idle();
      step();
      m_valid = 1'b0;
      m_addr  = $urandom;
      m_wdata = $urandom;
      m_wstrb = 4'($urandom_range(0, 15));
   endtask

   // One transaction. delay = ACTIVE cycle index on which the slave answers,
   // -1 for never. Returns inside the response cycle.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int delay,
                          input logic [31:0] rdata, input bit drop_valid);
      int          idx;
      int          n_act;
      bit          err;
      logic [31:0] exp_rd;
      idx = int'(addr[31:28]);
      if (idx >= NS) begin
         n_act = 0;
         err   = 1'b1;
      end else if (delay >= 0 && delay < TMO) begin
         n_act = delay + 1;
         err   = 1'b0;
      end else begin
         n_act = TMO;
         err   = 1'b1;
      end
      exp_rd = err ? ERR : rdata;
      step();
      m_valid = 1'b1;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
      exp_q.push_back({err, exp_rd});
      for (int k = 0; k < n_act; k++) begin
         step();
         if (drop_valid) m_valid = 1'b0;
         s_ready[idx]           = (k == delay);
         s_rdata[32*idx +: 32]  = rdata;
         exp_s_valid            = NS'(1) << idx;
         exp_state              = 2'd1;
      end
      step();
      exp_state     = 2'd2;
      exp_m_ready   = 1'b1;
      exp_bus_error = err;
      exp_m_rdata   = exp_rd;
      if (err) begin
         exp_err_addr = addr;
         bump         = 1'b1;
      end
      last_addr = addr;
   endtask

   task automatic after_negedge();
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NS; i++) sv_cnt[i] = 0;
      m_valid       = 1'b0;
      m_addr        = '0;
      m_wdata       = '0;
      m_wstrb       = '0;
      s_ready       = '0;
      s_rdata       = '0;
      exp_s_valid   = '0;
      exp_m_ready   = 1'b0;
      exp_bus_error = 1'b0;
      exp_m_rdata   = '0;
      exp_err_addr  = '0;
      exp_err_count = '0;
      exp_state     = 2'd0;
      bump          = 1'b0;
      last_addr     = '0;

      // reset values
      after_negedge();
      chk("rst_m_ready", 32'(m_ready), 32'd0);
      chk("rst_s_valid", 32'(s_valid), 32'd0);
      chk("rst_m_rdata", m_rdata, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_bus_error", 32'(bus_error), 32'd0);
      step();
      resetn = 1'b1;
      idle();

      // read slave 0, ready immediately
      snap();
      run_txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0);
      after_negedge();
      chk("t1_m_ready", 32'(m_ready), 32'd1);
      chk("t1_m_rdata", m_rdata, 32'h1234_5678);
      chk("t1_bus_error", 32'(bus_error), 32'd0);
      chk("t1_sv0_cycles", 32'(sv_delta(0)), 32'd1);
      idle();

      // write slave 1, ready after 3 wait cycles
      snap();
      run_txn(32'h1000_0000, 32'h0000_00A5, 4'hF, 3, 32'h0BAD_F00D, 1'b0);
      after_negedge();
      chk("t2_sv1_cycles", 32'(sv_delta(1)), 32'd4);
      chk("t2_sv_others", 32'(sv_delta(0) + sv_delta(2) + sv_delta(3)), 32'd0);
      chk("t2_ready_pulses", 32'(rdy_cnt - rdy_base), 32'd1);
      chk("t2_s_wdata", s_wdata, 32'h0000_00A5);
      idle();

      // unmapped access
      snap();
      run_txn(32'h5000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      after_negedge();
      chk("t3_m_rdata", m_rdata, 32'hDEADBEEF);
      chk("t3_bus_error", 32'(bus_error), 32'd1);
      chk("t3_err_addr", err_addr, 32'h5000_0000);
      chk("t3_no_s_valid", 32'(sv_delta(0) + sv_delta(1) + sv_delta(2) + sv_delta(3)), 32'd0);
      idle();
      after_negedge();
      chk("t3_err_count", 32'(err_count), 32'd1);

      // slave 2 never ready -> timeout after 8 cycles
      snap();
      run_txn(32'h2000_0100, 32'h0, 4'h0, -1, 32'h5555_AAAA, 1'b0);
      after_negedge();
      chk("t4_sv2_cycles", 32'(sv_delta(2)), 32'd8);
      chk("t4_bus_error", 32'(bus_error), 32'd1);
      chk("t4_m_rdata", m_rdata, 32'hDEADBEEF);
      idle();
      after_negedge();
      chk("t4_err_count", 32'(err_count), 32'd2);

      // timeout boundary: ready on the last allowed cycle, then one too late,
      // then a core that drops m_valid mid-transfer, all back to back
      run_txn(32'h3000_0004, 32'h0, 4'h0, 7, 32'hCAFE_0007, 1'b0);
      run_txn(32'h0000_0008, 32'h0, 4'h0, 8, 32'hCAFE_0008, 1'b0);
      run_txn(32'h1000_0020, 32'h0, 4'h0, 2, 32'h7777_1111, 1'b1);
      run_txn(32'h2000_0030, 32'h1111_2222, 4'h3, 1, 32'h0102_0304, 1'b0);
      run_txn(32'hF000_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      idle();
      after_negedge();
      chk("t5_err_count", 32'(err_count), 32'd4);
      chk("t5_err_addr", err_addr, 32'hF000_0000);

      // reset in the middle of an ACTIVE transfer
      step();
      m_valid = 1'b1;
      m_addr  = 32'h3000_0040;
      m_wstrb = 4'h0;
      for (int k = 0; k < 2; k++) begin
         step();
         s_ready[3]  = 1'b0;
         exp_s_valid = 4'b1000;
         exp_state   = 2'd1;
      end
      resetn        = 1'b0;
      m_valid       = 1'b0;
      exp_s_valid   = '0;
      exp_state     = 2'd0;
      exp_m_rdata   = '0;
      exp_err_addr  = '0;
      exp_err_count = '0;
      exp_q.delete();
      after_negedge();
      chk("t6_rst_s_valid", 32'(s_valid), 32'd0);
      chk("t6_rst_m_ready", 32'(m_ready), 32'd0);
      step();
      resetn = 1'b1;
      idle();
      run_txn(32'h3000_0044, 32'h0, 4'h0, 1, 32'h600D_600D, 1'b0);
      after_negedge();
      chk("t6_after_rdata", m_rdata, 32'h600D_600D);
      chk("t6_after_count", 32'(err_count), 32'd0);
      idle();

      // saturate the error counter with back-to-back unmapped accesses
      for (int i = 0; i < 32'h10002; i++) begin
         run_txn({4'($urandom_range(4, 15)), 28'($urandom)}, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      end
      idle();
      after_negedge();
      chk("t7_err_count_sat", 32'(err_count), 32'h0000_FFFF);
      chk("t7_err_addr", err_addr, last_addr);
      idle();
      idle();

      chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised successor to the fixed 3-way core bus mux between the picorv32 native memory port and N peripheral slaves (ram, io, uart, ...).
- Decodes a configurable address field to select a slave.
- Registers the response path.
- Adds a per-transaction timeout and an error response for unmapped or hung accesses, so the core never stalls forever.
- Keeps error status counters for debug.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- SEL_MSB, 31, MSB of address select field.
- SEL_LSB, 28, LSB of address select field; field value i selects slave i.
- TIMEOUT, 255, cycles a selected slave may take before error; 0 disables timeout.
- ERR_RDATA, 32'hDEADBEEF, read data returned on error response.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  1  core request valid.
- m_addr  in  32  core address.
- m_wdata  in  32  core write data.
- m_wstrb  in  4  core byte strobes (0 = read).
- m_ready  out  1  one-cycle transfer-complete pulse to core.
- m_rdata  out  32  registered read data to core.
- s_valid  out  NUM_SLAVES  per-slave request valid, one-hot or zero.
- s_addr  out  32  broadcast address (= m_addr).
- s_wdata  out  32  broadcast write data (= m_wdata).
- s_wstrb  out  4  broadcast strobes (= m_wstrb).
- s_ready  in  NUM_SLAVES  per-slave ready.
- s_rdata  in  32*NUM_SLAVES  packed slave read data; slave i at bits [32*i+31:32*i].
- bus_error  out  1  pulses together with m_ready when the response is an error.
- err_addr  out  32  address of most recent errored transaction.
- err_count  out  16  saturating count of errored transactions.

Behaviour:
- Reset (async, resetn=0): state IDLE; m_ready=0, m_rdata=0, s_valid=0, bus_error=0, err_addr=0, err_count=0, sel=0, timer=0. Reset mid-transaction aborts it; no response is issued.
- s_addr, s_wdata and s_wstrb are combinational pass-through. The core holds them stable while m_valid=1.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, m_valid=1, field index < NUM_SLAVES:
  - latch sel = index; clear timer; go to ACTIVE.
- IDLE, m_valid=1, field index >= NUM_SLAVES (unmapped):
  - go to RESP with error flag set.
  - m_rdata <= ERR_RDATA; err_addr <= m_addr.
- ACTIVE:
  - s_valid[sel]=1 (registered decode, one-hot); other bits 0.
  - s_ready[sel]=1: m_rdata <= s_rdata[sel]; error flag cleared; go to RESP.
  - Else timer increments. If TIMEOUT!=0 and timer==TIMEOUT-1 without ready:
    - m_rdata <= ERR_RDATA; err_addr <= m_addr; error flag set; go to RESP.
  - s_valid drops on the RESP transition.
- RESP:
  - m_ready=1 for exactly one cycle; bus_error = error flag.
  - err_count increments on each error, saturating at 16'hFFFF.
  - Next state IDLE unconditionally.
- Latency: m_valid rise at cycle 0, slave ready in first ACTIVE cycle (cycle 1) -> m_ready at cycle 2. Unmapped -> m_ready at cycle 1.
- m_valid is sampled only in IDLE. If m_valid deasserts mid-ACTIVE (protocol violation), the transaction still completes.
- s_ready from non-selected slaves is ignored in all states.
- s_ready in IDLE or RESP is ignored.
- Back-to-back: a new m_valid seen in the IDLE cycle after RESP starts a new transaction with no bubble beyond the IDLE cycle.
- m_rdata holds its last value between responses. Write transactions also capture s_rdata, so the value is don't-care to the core.

Test Plan:
- Read slave 0 at 0x0000_0010, s_ready[0] high immediately, s_rdata0=0x12345678 -> s_valid=4'b0001 at cycle 1, m_ready at cycle 2 with m_rdata=0x12345678, bus_error=0.
- Write slave 1 at 0x1000_0000, wstrb=4'hF, wdata=0xA5, s_ready[1] after 3 wait cycles -> s_valid=4'b0010 for 4 cycles, s_wdata=0xA5, single m_ready pulse, s_valid[0,2,3] never high.
- Access 0x5000_0000 with NUM_SLAVES=4 -> no s_valid, m_ready at cycle 1, m_rdata=0xDEADBEEF, bus_error=1, err_addr=0x5000_0000, err_count=1.
- TIMEOUT=8, slave 2 never ready -> s_valid[2] high exactly 8 cycles, then m_ready+bus_error, m_rdata=0xDEADBEEF, err_count increments.
- Assert resetn=0 during ACTIVE -> s_valid=0, m_ready=0 immediately; after release, state IDLE and next transaction completes normally.
- Force 0x10000 unmapped accesses -> err_count saturates at 0xFFFF.
